// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM arbiter: FSM states, the latched aux
// request, default timing constants and the bank write-enable decode.
package vram_arb_pkg;

  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_MAX_RETRY  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUX_RD = 2'd1,
    AUX_WR = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  din;
  } aux_req_t;

  // Returns {we_hi, we_lo}; address bit 16 selects the hi bank.
  function automatic logic [1:0] bank_we(input logic we, input logic hi_bank);
    return {we & hi_bank, we & ~hi_bank};
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares the two-bank VRAM between the VDP (absolute priority in its slot)
// and one auxiliary requester served in the gaps, with transparent retry.
//
// state  | meaning
// IDLE   | no aux access in flight; waiting for aux_req in a non-slot cycle
// AUX_RD | aux read holding its address until RD_LATENCY clean cycles elapse
// AUX_WR | aux write waiting for a non-slot cycle to land
// DONE   | one-cycle aux_ack; retry count cleared
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vdp_slot,
  input  logic [16:0] vdp_addr,
  input  logic        vdp_we,
  input  logic [7:0]  vdp_din,
  output logic [15:0] vdp_q,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [16:0] aux_addr,
  input  logic [7:0]  aux_din,
  output logic        aux_ack,
  output logic [7:0]  aux_dout,
  output logic        aux_starved,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we_lo,
  output logic        mem_we_hi,
  input  logic [7:0]  mem_q_lo,
  input  logic [7:0]  mem_q_hi
);

  localparam logic [2:0] LP_RD_LAT    = 3'(RD_LATENCY);
  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  arb_state_t  r_state;
  aux_req_t    r_req;
  logic [2:0]  r_lat_cnt;
  logic [3:0]  r_retry_cnt;
  logic [7:0]  r_aux_dout;
  logic        r_starved;

  logic [3:0]  w_retry_next;
  logic        w_aux_busy;
  logic        w_retry_hit;
  logic [1:0]  w_we;

  assign w_aux_busy   = (r_state == AUX_RD) || (r_state == AUX_WR);
  assign w_retry_hit  = w_aux_busy && vdp_slot;
  assign w_retry_next = (r_retry_cnt == LP_MAX_RETRY) ? r_retry_cnt : r_retry_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_lat_cnt   <= '0;
      r_retry_cnt <= '0;
      r_aux_dout  <= 8'h00;
      r_starved   <= 1'b0;
    end else if (!enable) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (aux_req && !vdp_slot) begin
            r_req     <= '{we: aux_we, addr: aux_addr, din: aux_din};
            r_state   <= aux_we ? AUX_WR : AUX_RD;
            r_lat_cnt <= aux_we ? 3'd0 : 3'd1;
          end
        end
        AUX_WR: begin
          if (!vdp_slot) r_state <= DONE;
        end
        AUX_RD: begin
          // A slot moves the address away from the aux target, so the
          // read latency window starts over.
          if (vdp_slot) begin
            r_lat_cnt <= 3'd1;
          end else if (r_lat_cnt == LP_RD_LAT) begin
            r_aux_dout <= r_req.addr[16] ? mem_q_hi : mem_q_lo;
            r_state    <= DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_lat_cnt   <= '0;
          r_retry_cnt <= '0;
        end
        default: r_state <= IDLE;
      endcase

      if (w_retry_hit) begin
        r_retry_cnt <= w_retry_next;
        if (w_retry_next == LP_MAX_RETRY) r_starved <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr = vdp_addr[15:0];
    mem_data = vdp_din;
    w_we     = 2'b00;
    if (!reset_n || !enable) begin
      mem_addr = '1;
      mem_data = '1;
    end else if (vdp_slot) begin
      w_we = bank_we(vdp_we, vdp_addr[16]);
    end else if (w_aux_busy) begin
      mem_addr = r_req.addr[15:0];
      mem_data = r_req.din;
      w_we     = bank_we(r_req.we && (r_state == AUX_WR), r_req.addr[16]);
    end
  end

  assign mem_we_hi   = w_we[1];
  assign mem_we_lo   = w_we[0];
  assign vdp_q       = {mem_q_hi, mem_q_lo};
  assign aux_ack     = (r_state == DONE) && enable;
  assign aux_dout    = r_aux_dout;
  assign aux_starved = r_starved;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a two-bank VRAM model
// and a reference model built on slot windows rather than FSM states.
module tb_vram_arbiter;

  localparam int RD   = 2;
  localparam int MAXR = 15;

  logic        clk = 1'b0;
  logic        reset_n, enable, vdp_slot, vdp_we;
  logic [16:0] vdp_addr;
  logic [7:0]  vdp_din;
  logic [15:0] vdp_q;
  logic        aux_req, aux_we, aux_ack, aux_starved;
  logic [16:0] aux_addr;
  logic [7:0]  aux_din, aux_dout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, mem_q_lo, mem_q_hi;
  logic        mem_we_lo, mem_we_hi;

  always #5 clk = ~clk;

  vram_arbiter #(.RD_LATENCY(RD), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .vdp_slot(vdp_slot), .vdp_addr(vdp_addr), .vdp_we(vdp_we), .vdp_din(vdp_din), .vdp_q(vdp_q),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_ack(aux_ack), .aux_dout(aux_dout), .aux_starved(aux_starved),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi),
    .mem_q_lo(mem_q_lo), .mem_q_hi(mem_q_hi)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         ack_cyc;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] vram   [0:131071];
  logic [7:0] shadow [0:131071];
  bit         mem_init = 1'b0;
  logic [7:0] last_rd;
  bit         model_starved;
  logic [63:0] rp;
  int          rmode;

  function automatic logic [7:0] init_val(input logic [16:0] a);
    if (a == 17'h00010) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
  endfunction

  function automatic logic [16:0] rand_addr();
    logic [16:0] a;
    a = {1'($urandom_range(0, 1)), 11'h000, 5'($urandom_range(0, 31))};
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Registered-read two-bank VRAM
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 131072; i++) vram[i] <= init_val(17'(i));
      mem_init <= 1'b1;
    end else begin
      if (mem_we_lo) vram[{1'b0, mem_addr}] <= mem_data;
      if (mem_we_hi) vram[{1'b1, mem_addr}] <= mem_data;
    end
    mem_q_lo <= vram[{1'b0, mem_addr}];
    mem_q_hi <= vram[{1'b1, mem_addr}];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && aux_ack) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack with no pending request at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          chk("aux_dout", 32'(aux_dout), 32'(e.data));
        end
      end
    end
  end

  // pat[k] = vdp_slot in the k-th cycle after the request is raised.
  task automatic run_txn(input logic we, input logic [16:0] addr, input logic [7:0] din,
                         input logic [63:0] pat, input bit fix_v,
                         input logic [16:0] fv_addr, input logic [7:0] fv_din);
    logic        vwe [64];
    logic [16:0] va  [64];
    logic [7:0]  vd  [64];
    int c0, kd, ka, run, retries, s;
    logic [7:0]  exp_d, cvd, ed;
    logic [16:0] cva;
    logic [15:0] ea;
    logic [1:0]  ew;
    logic        p, cwe;
    bit          got;
    exp_t        e;
    for (int k = 0; k < 64; k++) begin
      vwe[k] = fix_v ? pat[k] : 1'($urandom_range(0, 1));
      va[k]  = fix_v ? fv_addr : rand_addr();
      vd[k]  = fix_v ? fv_din : 8'($urandom);
    end
    // Accepted in the first slot-free cycle; completes after 1 (write) or
    // RD (read) consecutive slot-free cycles following acceptance.
    c0 = 0;
    while (c0 < 63 && pat[c0]) c0++;
    kd = 63;
    run = 0;
    for (int k = c0 + 1; k < 64; k++) begin
      run = pat[k] ? 0 : run + 1;
      if (run == (we ? 1 : RD)) begin
        kd = k;
        break;
      end
    end
    ka = kd + 1;
    retries = 0;
    for (int k = c0 + 1; k <= kd; k++) if (pat[k]) retries++;
    if (retries >= MAXR) model_starved = 1'b1;
    exp_d = last_rd;
    for (int k = 0; k < ka; k++) begin
      if (k == kd) begin
        if (we) shadow[addr] = din;
        else    exp_d = shadow[addr];
      end
      if (pat[k] && vwe[k]) shadow[va[k]] = vd[k];
    end
    last_rd = exp_d;

    @(negedge clk);
    s = cyc;
    e.ack_cyc = s + ka;
    e.data    = exp_d;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (aux_ack) begin
        got = 1'b1;
        aux_req = 1'b0;
        vdp_slot = 1'b0;
        vdp_we = 1'b0;
        break;
      end
      p   = (k < 64) ? pat[k] : 1'b0;
      cva = (k < 64) ? va[k] : rand_addr();
      cvd = (k < 64) ? vd[k] : 8'h00;
      cwe = (k < 64) ? vwe[k] : 1'b0;
      aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_din = din;
      vdp_slot = p; vdp_we = cwe; vdp_addr = cva; vdp_din = cvd;
      #1;
      if (p) begin
        ea = cva[15:0]; ed = cvd; ew = {cwe & cva[16], cwe & ~cva[16]};
      end else if (k > c0 && k <= kd) begin
        ea = addr[15:0]; ed = din;
        ew = (we && k == kd) ? {addr[16], ~addr[16]} : 2'b00;
      end else begin
        ea = cva[15:0]; ed = cvd; ew = 2'b00;
      end
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_data", 32'(mem_data), 32'(ed));
      chk("mem_we", 32'({mem_we_hi, mem_we_lo}), 32'(ew));
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: no aux_ack within 200 cycles for addr %0h", addr);
      aux_req = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1;
    vdp_slot = 1'b0; vdp_we = 1'b0; vdp_addr = '0; vdp_din = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_din = '0;
    last_rd = 8'h00; model_starved = 1'b0;
    for (int i = 0; i < 131072; i++) shadow[i] = init_val(17'(i));

    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'hFFFF);
    chk("rst_mem_data", 32'(mem_data), 32'hFF);
    chk("rst_mem_we", 32'({mem_we_hi, mem_we_lo}), 32'd0);
    chk("rst_ack", 32'(aux_ack), 32'd0);
    chk("rst_dout", 32'(aux_dout), 32'd0);
    chk("rst_starved", 32'(aux_starved), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 32'(aux_ack), 32'd0);

    run_txn(1'b1, 17'h1_2345, 8'hA5, 64'h0, 1'b0, '0, '0);
    run_txn(1'b0, 17'h0_0010, 8'h00, 64'h0, 1'b0, '0, '0);
    run_txn(1'b0, 17'h1_2345, 8'h00, 64'h0, 1'b0, '0, '0);
    run_txn(1'b0, 17'h0_0007, 8'h00, 64'h4, 1'b0, '0, '0);
    run_txn(1'b1, 17'h0_0200, 8'h77, 64'h5555, 1'b1, 17'h0_0100, 8'hC3);
    run_txn(1'b0, 17'h0_0100, 8'h00, 64'h0, 1'b0, '0, '0);
    run_txn(1'b0, 17'h0_0200, 8'h00, 64'h0, 1'b0, '0, '0);

    run_txn(1'b0, 17'h1_0003, 8'h00, 64'h7FFE, 1'b0, '0, '0);
    chk("starved_after_14", 32'(aux_starved), 32'(model_starved));

    for (int t = 0; t < 120; t++) begin
      rp = '0;
      rmode = int'($urandom_range(0, 2));
      for (int b = 0; b < 40; b++) begin
        if (rmode == 1)      rp[b] = ($urandom_range(0, 3) == 0);
        else if (rmode == 2) rp[b] = 1'($urandom_range(0, 1));
      end
      run_txn(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), rp, 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("starved_random", 32'(aux_starved), 32'(model_starved));

    run_txn(1'b0, 17'h0_0011, 8'h00, 64'h1F_FFFE, 1'b0, '0, '0);
    chk("starved_after_20", 32'(aux_starved), 32'd1);

    // Disabled: memory side idle, request stays pending
    @(negedge clk);
    enable = 1'b0; aux_req = 1'b1; aux_we = 1'b0; aux_addr = 17'h1_0005;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      vdp_slot = k[0]; vdp_we = 1'b1; vdp_addr = rand_addr(); vdp_din = 8'($urandom);
      #1;
      chk("dis_mem_addr", 32'(mem_addr), 32'hFFFF);
      chk("dis_mem_data", 32'(mem_data), 32'hFF);
      chk("dis_mem_we", 32'({mem_we_hi, mem_we_lo}), 32'd0);
      chk("dis_ack", 32'(aux_ack), 32'd0);
    end
    vdp_slot = 1'b1; vdp_we = 1'b0;
    enable = 1'b1;
    run_txn(1'b0, 17'h1_0005, 8'h00, 64'h0, 1'b0, '0, '0);

    // Reset in the middle of an aux write
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 17'h1_2345; aux_din = 8'h5A;
    vdp_slot = 1'b0; vdp_we = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_we", 32'({mem_we_hi, mem_we_lo}), 32'b10);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'({mem_we_hi, mem_we_lo}), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'hFFFF);
    chk("midrst_data", 32'(mem_data), 32'hFF);
    chk("midrst_ack", 32'(aux_ack), 32'd0);
    chk("midrst_dout", 32'(aux_dout), 32'd0);
    chk("midrst_starved", 32'(aux_starved), 32'd0);
    aux_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_midrst_ack", 32'(aux_ack), 32'd0);
    end
    last_rd = 8'h00;
    model_starved = 1'b0;
    run_txn(1'b0, 17'h1_2345, 8'h00, 64'h0, 1'b0, '0, '0);
    chk("starved_cleared", 32'(aux_starved), 32'(model_starved));

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the 128 KB VRAM (two 64 KB banks, lo/hi) between the VDP and one auxiliary requester, such as a state loader, debugger or DMA.
- The VDP always wins its access slot, which is the cycle its slot strobe is high.
- The auxiliary port uses a req/ack handshake and is served only in non-VDP cycles; an access interrupted by a VDP slot is transparently retried.
- Sits between the VDP device and the vram_bus.

Parameters:
- RD_LATENCY, 2, clocks an aux read must hold its address before q is valid (1..7).
- MAX_RETRY, 15, retry count at which aux_starved asserts (4-bit saturating).

Ports:
- clk  in  1  system clock (cpu_bus.clk domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  device enable; 0 forces the memory side idle
- vdp_slot  in  1  VDP owns memory this cycle (DLClk-qualified strobe)
- vdp_addr  in  17  VDP address; bit 16 selects the hi bank
- vdp_we  in  1  VDP write, active high, valid with vdp_slot
- vdp_din  in  8  VDP write data
- vdp_q  out  16  {mem_q_hi, mem_q_lo}, passed straight through
- aux_req  in  1  aux request, held until aux_ack
- aux_we  in  1  1 = write, 0 = read; stable while aux_req is high
- aux_addr  in  17  aux address; stable while aux_req is high
- aux_din  in  8  aux write data
- aux_ack  out  1  one-clock completion pulse
- aux_dout  out  8  read data, valid from aux_ack until the next read completes
- aux_starved  out  1  sticky flag: retry count reached MAX_RETRY
- mem_addr  out  16  VRAM address
- mem_data  out  8  VRAM write data
- mem_we_lo  out  1  lo bank write enable
- mem_we_hi  out  1  hi bank write enable
- mem_q_lo  in  8  lo bank read data
- mem_q_hi  in  8  hi bank read data

Behaviour:
- Reset values:
  - state IDLE, lat_cnt 0, retry_cnt 0.
  - aux_ack 0, aux_dout 8'h00, aux_starved 0.
  - While reset_n is low: mem_we_lo/hi 0, mem_addr 16'hFFFF, mem_data 8'hFF.
- enable = 0: mem_addr '1, mem_data '1, both we 0, aux_ack never pulses, FSM held in IDLE. Requests stay pending.
- Memory mux (combinational from state and vdp_slot):
  - vdp_slot = 1: drive VDP signals (addr[15:0], din, we_lo = vdp_we & ~addr[16], we_hi = vdp_we & addr[16]). This overrides every aux state.
  - Otherwise, in AUX_RD or AUX_WR: drive aux signals the same way (we only in AUX_WR).
  - Otherwise: drive the VDP address with both we forced 0.
- FSM states: IDLE, AUX_RD, AUX_WR, DONE.
  - IDLE: if aux_req & ~vdp_slot, go to AUX_WR when aux_we = 1, else AUX_RD with lat_cnt = 1. A request arriving in a vdp_slot cycle waits.
  - AUX_WR: if ~vdp_slot, the write happens this cycle; go to DONE. If vdp_slot, no aux write; retry_cnt++ and stay.
  - AUX_RD, ~vdp_slot: lat_cnt++. When lat_cnt == RD_LATENCY, capture aux_dout = addr[16] ? mem_q_hi : mem_q_lo and go to DONE.
  - AUX_RD, vdp_slot: lat_cnt = 1 (address was disturbed, restart), retry_cnt++.
  - DONE: aux_ack = 1 for exactly this cycle, retry_cnt cleared, go to IDLE. A new request is accepted no earlier than the following cycle, so back-to-back accesses are separated by at least one idle clock.
- Latency with no VDP interference:
  - Write: ack 2 clocks after request sampled.
  - Read: ack RD_LATENCY+1 clocks after request sampled.
- aux_starved sets when retry_cnt reaches MAX_RETRY. It stays set until reset. retry_cnt saturates at MAX_RETRY.
- Dropping aux_req mid-access is a protocol violation: the access completes and ack is still issued.
- Reset asserted mid-access: the write is abandoned (we deasserts asynchronously), no ack is issued, and aux_dout returns to 0.

Decomposition:
- Package vram_arb_pkg holds:
  - the state enum typedef (IDLE, AUX_RD, AUX_WR, DONE);
  - an aux request struct {we, addr[16:0], din[7:0]};
  - the default latency constant.
- No sub-module. The bank-select/we decode is a small function in the package, shared with the mux.

Test Plan:
- Reset, vdp_slot = 0, aux write addr 17'h1_2345 data 8'hA5 -> mem_we_hi = 1 for one clock with mem_addr 16'h2345 and mem_data A5; aux_ack 2 clocks after request; mem_we_lo never set.
- Aux read addr 17'h0_0010, mem_q_lo = 8'h3C, RD_LATENCY = 2 -> aux_ack 3 clocks after request; aux_dout = 8'h3C.
- vdp_slot pulse on the 2nd cycle of an aux read -> that cycle mem_addr = VDP address; lat_cnt restarts; ack delayed by 2 clocks; data still correct.
- vdp_slot and aux write coincide every other cycle -> aux write lands only in a non-slot cycle; VDP write to 17'h0_0100 issued in the slot is unaffected.
- vdp_slot held high for 20 clocks with aux_req pending in AUX_RD -> aux_starved = 1 after 15 retries; ack follows within RD_LATENCY+1 clocks once the slot drops.
- enable = 0 with aux_req high -> mem outputs all-ones / we 0, no ack; enable = 1 -> request served normally.
- reset_n pulsed low during AUX_WR -> we deasserts immediately, no aux_ack, all outputs return to their reset values.
